// File: rtl/multicycle_core_seq_if.sv
// Fetch and load/store handshake bundle between multicycle_core_seq (master)
// and the instruction/data memory ports (slave).
interface multicycle_core_seq_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            ifu_req_valid;
   logic [XLEN-1:0] ifu_req_addr;
   logic            ifu_req_ready;
   logic            ifu_resp_valid;
   logic [31:0]     ifu_resp_inst;
   logic            ifu_resp_ready;
   logic            lsu_req_valid;
   logic            lsu_req_ready;
   logic            lsu_resp_valid;
   logic            lsu_resp_err;

   modport master (
      output ifu_req_valid, ifu_req_addr, ifu_resp_ready, lsu_req_valid,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_inst, lsu_req_ready,
             lsu_resp_valid, lsu_resp_err
   );

   modport slave (
      input  ifu_req_valid, ifu_req_addr, ifu_resp_ready, lsu_req_valid,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_inst, lsu_req_ready,
             lsu_resp_valid, lsu_resp_err
   );
endinterface

// File: rtl/multicycle_core_seq.sv
// Multi-cycle sequencer: owns pc/inst, drives fetch and LSU handshakes, commits once per instr.
// Optional SEQ_PERF_CNT_EN adds 64-bit perf_cycle / perf_instret counters.
module multicycle_core_seq #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_core_seq_if.master bus,
   input  logic                 dec_mem_rd,
   input  logic                 dec_mem_wr,
   input  logic                 dec_gpr_wen,
   input  logic                 dec_csr_wen,
   input  logic                 dec_jump,
   input  logic                 dec_ebreak,
   input  logic [XLEN-1:0]      jump_pc,
   output logic [XLEN-1:0]      pc,
   output logic [31:0]          inst,
   output logic                 gpr_wen,
   output logic                 csr_wen,
   output logic                 commit,
   output logic                 halted,
   output logic [1:0]           halt_cause
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [63:0]          perf_cycle,
   output logic [63:0]          perf_instret
`endif
);

   localparam logic [31:0] NopInst = 32'h0000_0013;

   typedef enum logic [2:0] {
      StFetchReq, StFetchWait, StExec, StMemReq, StMemWait, StWb, StHalt
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     inst_q, inst_d;
   logic [1:0]      cause_q, cause_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFetchReq;
         pc_q    <= RESET_PC;
         inst_q  <= NopInst;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cause_d = cause_q;
      unique case (state_q)
         StFetchReq: if (bus.ifu_req_ready) state_d = StFetchWait;
         StFetchWait: begin
            if (bus.ifu_resp_valid) begin
               state_d = StExec;
               inst_d  = bus.ifu_resp_inst;
            end
         end
         StExec: begin
            if (dec_ebreak) begin
               state_d = StHalt;
               cause_d = 2'b01;
            end else if (dec_mem_rd || dec_mem_wr) begin
               state_d = StMemReq;
            end else begin
               state_d = StWb;
            end
         end
         StMemReq: begin
            // A response coincident with acceptance skips the wait state.
            if (bus.lsu_req_ready) begin
               if (!bus.lsu_resp_valid) begin
                  state_d = StMemWait;
               end else if (bus.lsu_resp_err) begin
                  state_d = StHalt;
                  cause_d = 2'b10;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StMemWait: begin
            if (bus.lsu_resp_valid) begin
               if (bus.lsu_resp_err) begin
                  state_d = StHalt;
                  cause_d = 2'b10;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            state_d = StFetchReq;
            pc_d    = dec_jump ? jump_pc : pc_q + XLEN'(PC_STEP);
         end
         StHalt:  state_d = StHalt;
         default: state_d = StFetchReq;
      endcase
   end

   always_comb begin
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_resp_ready = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      gpr_wen            = 1'b0;
      csr_wen            = 1'b0;
      commit             = 1'b0;
      halted             = 1'b0;
      // Reset state is StFetchReq, so the request must be masked while reset is held.
      if (rst) begin
         unique case (state_q)
            StFetchReq:  bus.ifu_req_valid  = 1'b1;
            StFetchWait: bus.ifu_resp_ready = 1'b1;
            StMemReq:    bus.lsu_req_valid  = 1'b1;
            StWb: begin
               gpr_wen = dec_gpr_wen;
               csr_wen = dec_csr_wen;
               commit  = 1'b1;
            end
            StHalt:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.ifu_req_addr = pc_q;
   assign pc               = pc_q;
   assign inst             = inst_q;
   assign halt_cause       = cause_q;

`ifdef SEQ_PERF_CNT_EN
   logic [63:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_q   <= 64'd0;
         instret_q <= 64'd0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
         if (commit) instret_q <= instret_q + 64'd1;
      end
   end

   assign perf_cycle   = cycle_q;
   assign perf_instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_core_seq.sv
// Randomized bench for multicycle_core_seq: a per-instruction timeline model predicts every
// output on every cycle; a few literal pins anchor the model to hand-computed values.
module tb_multicycle_core_seq;
   localparam int unsigned XLEN   = 32;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   localparam int PH_FREQ  = 0;
   localparam int PH_FWAIT = 1;
   localparam int PH_EXEC  = 2;
   localparam int PH_MREQ  = 3;
   localparam int PH_MWAIT = 4;
   localparam int PH_WB    = 5;
   localparam int PH_HALT  = 6;
   localparam int PH_RST   = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dec_mem_rd = 1'b0, dec_mem_wr = 1'b0, dec_gpr_wen = 1'b0;
   logic        dec_csr_wen = 1'b0, dec_jump = 1'b0, dec_ebreak = 1'b0;
   logic [31:0] jump_pc = 32'h0;
   logic [31:0] pc, inst;
   logic        gpr_wen, csr_wen, commit, halted;
   logic [1:0]  halt_cause;
`ifdef SEQ_PERF_CNT_EN
   logic [63:0] perf_cycle, perf_instret;
`endif

   multicycle_core_seq_if #(.XLEN(XLEN)) bus ();

   multicycle_core_seq #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dec_mem_rd  (dec_mem_rd),
      .dec_mem_wr  (dec_mem_wr),
      .dec_gpr_wen (dec_gpr_wen),
      .dec_csr_wen (dec_csr_wen),
      .dec_jump    (dec_jump),
      .dec_ebreak  (dec_ebreak),
      .jump_pc     (jump_pc),
      .pc          (pc),
      .inst        (inst),
      .gpr_wen     (gpr_wen),
      .csr_wen     (csr_wen),
      .commit      (commit),
      .halted      (halted),
      .halt_cause  (halt_cause)
`ifdef SEQ_PERF_CNT_EN
      ,
      .perf_cycle  (perf_cycle),
      .perf_instret(perf_instret)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        ifu_req_ready, ifu_resp_valid;
      logic [31:0] ifu_resp_inst;
      logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
      logic [5:0]  dec;  // {rd, wr, gpr, csr, jump, ebreak}
      logic [31:0] jump_pc;
      logic        e_ifu_req_valid, e_ifu_resp_ready, e_lsu_req_valid;
      logic        e_gpr_wen, e_csr_wen, e_commit, e_halted;
      logic [1:0]  e_cause;
      logic [31:0] e_pc, e_inst;
      logic [63:0] e_cyc, e_ret;
      logic        lit_addr_en;
      logic [31:0] lit_addr;
      logic        lit_commit_en, lit_cause_en;
      logic [1:0]  lit_cause;
   } cyc_t;

   cyc_t q[$];
   cyc_t cur;
   bit   cur_en = 1'b0;
   int   n_vec  = 0;
   int   n_miss = 0;

   // Architectural model state
   logic [31:0] m_pc = RST_PC, m_inst = NOP;
   logic        m_halted = 1'b0;
   logic [1:0]  m_cause = 2'b00;
   logic [63:0] m_cyc = 64'd0, m_ret = 64'd0;
   // Decode view of the instruction being generated
   logic [5:0]  d_dec = 6'd0;
   logic [31:0] d_jpc = 32'h0, d_word = NOP;
   bit          force_stray = 1'b0;

   task automatic emit(input int ph, input int a = 0, input int b = 0, input int e = 0);
      cyc_t c;
      c = '0;
      c.rst            = (ph != PH_RST);
      c.ifu_req_ready  = ($urandom_range(0, 3) == 0);
      c.ifu_resp_valid = ($urandom_range(0, 3) == 0);
      c.ifu_resp_inst  = $urandom;
      c.lsu_req_ready  = ($urandom_range(0, 3) == 0);
      c.lsu_resp_valid = ($urandom_range(0, 3) == 0);
      c.lsu_resp_err   = 1'($urandom_range(0, 1));
      c.dec            = 6'($urandom);
      c.jump_pc        = $urandom;
      if (ph == PH_EXEC || ph == PH_WB) begin
         c.dec     = d_dec;
         c.jump_pc = d_jpc;
      end
      case (ph)
         PH_FREQ: begin
            c.ifu_req_ready = (a != 0);
            if (force_stray) begin
               c.lsu_resp_valid = 1'b1;
               c.lsu_resp_err   = 1'b0;
               force_stray      = 1'b0;
            end
         end
         PH_FWAIT: begin
            c.ifu_resp_valid = (a != 0);
            if (a != 0) c.ifu_resp_inst = d_word;
         end
         PH_MREQ: begin
            c.lsu_req_ready = (a != 0);
            if (a != 0) begin
               c.lsu_resp_valid = (b != 0);
               if (b != 0) c.lsu_resp_err = (e != 0);
            end
         end
         PH_MWAIT: begin
            c.lsu_resp_valid = (a != 0);
            if (a != 0) c.lsu_resp_err = (e != 0);
         end
         default: ;
      endcase
      if (ph == PH_RST) begin
         m_pc = RST_PC; m_inst = NOP; m_halted = 1'b0; m_cause = 2'b00;
         m_cyc = 64'd0; m_ret = 64'd0;
      end
      c.e_pc             = m_pc;
      c.e_inst           = m_inst;
      c.e_halted         = m_halted;
      c.e_cause          = m_cause;
      c.e_cyc            = m_cyc;
      c.e_ret            = m_ret;
      c.e_ifu_req_valid  = (ph == PH_FREQ);
      c.e_ifu_resp_ready = (ph == PH_FWAIT);
      c.e_lsu_req_valid  = (ph == PH_MREQ);
      c.e_commit         = (ph == PH_WB);
      c.e_gpr_wen        = (ph == PH_WB) && d_dec[3];
      c.e_csr_wen        = (ph == PH_WB) && d_dec[2];
      q.push_back(c);
      if (ph != PH_RST) m_cyc = m_cyc + 64'd1;
      if (ph == PH_FWAIT && a != 0) m_inst = d_word;
      if (ph == PH_WB) begin
         m_ret = m_ret + 64'd1;
         m_pc  = d_dec[1] ? d_jpc : m_pc + 32'd4;
      end
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 ebreak (other decode bits random). cut>=0 stops in MEM_WAIT.
   task automatic gen_instr(input int r, input int d, input int kind, input int a, input int w,
                            input int same, input int err, input int gpr, input int csr,
                            input int jmp, input logic [31:0] jpc, input int cut = -1);
      if (kind == 3) d_dec = {6'($urandom)} | 6'b000001;
      else d_dec = {kind == 1, kind == 2, gpr != 0, csr != 0, jmp != 0, 1'b0};
      d_jpc  = jpc;
      d_word = $urandom;
      for (int i = 0; i < r; i++) emit(PH_FREQ, 0);
      emit(PH_FREQ, 1);
      for (int i = 0; i < d; i++) emit(PH_FWAIT, 0);
      emit(PH_FWAIT, 1);
      emit(PH_EXEC);
      if (kind == 3) begin
         m_halted = 1'b1; m_cause = 2'b01;
         return;
      end
      if (kind == 1 || kind == 2) begin
         for (int i = 0; i < a; i++) emit(PH_MREQ, 0);
         if (same != 0) begin
            emit(PH_MREQ, 1, 1, err);
         end else begin
            emit(PH_MREQ, 1, 0, 0);
            if (cut >= 0) begin
               for (int i = 0; i < cut; i++) emit(PH_MWAIT, 0);
               return;
            end
            for (int i = 0; i < w; i++) emit(PH_MWAIT, 0);
            emit(PH_MWAIT, 1, 0, err);
         end
         if (err != 0) begin
            m_halted = 1'b1; m_cause = 2'b10;
            return;
         end
      end
      emit(PH_WB);
   endtask

   task automatic pin_addr(input int idx, input logic [31:0] v);
      cyc_t t;
      t = q[idx]; t.lit_addr_en = 1'b1; t.lit_addr = v; q[idx] = t;
   endtask

   task automatic pin_commit(input int idx);
      cyc_t t;
      t = q[idx]; t.lit_commit_en = 1'b1; q[idx] = t;
   endtask

   task automatic pin_cause(input int idx, input logic [1:0] v);
      cyc_t t;
      t = q[idx]; t.lit_cause_en = 1'b1; t.lit_cause = v; q[idx] = t;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cur_en) begin
         n_vec++;
         check("ifu_req_valid", 64'(bus.ifu_req_valid), 64'(cur.e_ifu_req_valid));
         check("ifu_req_addr", 64'(bus.ifu_req_addr), 64'(cur.e_pc));
         check("ifu_resp_ready", 64'(bus.ifu_resp_ready), 64'(cur.e_ifu_resp_ready));
         check("lsu_req_valid", 64'(bus.lsu_req_valid), 64'(cur.e_lsu_req_valid));
         check("pc", 64'(pc), 64'(cur.e_pc));
         check("inst", 64'(inst), 64'(cur.e_inst));
         check("gpr_wen", 64'(gpr_wen), 64'(cur.e_gpr_wen));
         check("csr_wen", 64'(csr_wen), 64'(cur.e_csr_wen));
         check("commit", 64'(commit), 64'(cur.e_commit));
         check("halted", 64'(halted), 64'(cur.e_halted));
         check("halt_cause", 64'(halt_cause), 64'(cur.e_cause));
         if (cur.lit_addr_en) check("lit_fetch_addr", 64'(bus.ifu_req_addr), 64'(cur.lit_addr));
         if (cur.lit_commit_en) check("lit_commit", 64'(commit), 64'd1);
         if (cur.lit_cause_en) begin
            check("lit_halted", 64'(halted), 64'd1);
            check("lit_halt_cause", 64'(halt_cause), 64'(cur.lit_cause));
         end
`ifdef SEQ_PERF_CNT_EN
         check("perf_cycle", perf_cycle, cur.e_cyc);
         check("perf_instret", perf_instret, cur.e_ret);
`endif
      end
   end

   initial begin
      int s, k, kind, err, cut;
      bus.ifu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.ifu_resp_inst  = 32'h0;
      bus.lsu_req_ready  = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      bus.lsu_resp_err   = 1'b0;

      emit(PH_RST); emit(PH_RST);
      // Zero-wait addi: commit on the 4th cycle, next fetch at +4
      s = q.size(); gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0); pin_commit(s + 3);
      s = q.size(); gen_instr(3, 2, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
      pin_addr(s, 32'h8000_0004); pin_commit(q.size() - 1);
      // Load answered 5 cycles after accept
      s = q.size(); gen_instr(0, 0, 1, 0, 4, 0, 0, 1, 0, 0, 32'h0);
      pin_addr(s, 32'h8000_0008); pin_commit(s + 9);
      // Jump, then sequential wrap past all-ones
      s = q.size(); gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h8000_0100);
      pin_addr(s, 32'h8000_000C);
      s = q.size(); gen_instr(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      pin_addr(s, 32'h8000_0100);
      s = q.size(); gen_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
      pin_addr(s, 32'hFFFF_FFFC);
      s = q.size(); gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
      pin_addr(s, 32'h0000_0000);
      // Faulting store halts with cause 10
      gen_instr(1, 1, 2, 1, 2, 0, 1, 1, 1, 0, 32'h0);
      s = q.size(); repeat (3) emit(PH_HALT);
      pin_cause(s, 2'b10); pin_cause(s + 2, 2'b10);
      emit(PH_RST);
      s = q.size(); gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0); pin_addr(s, RST_PC);
      gen_instr(0, 0, 3, 0, 0, 0, 0, 1, 1, 1, 32'h1234_5678);
      s = q.size(); repeat (4) emit(PH_HALT);
      pin_cause(s, 2'b01); pin_cause(s + 3, 2'b01);
      // Reset in MEM_WAIT, stray LSU response after release
      emit(PH_RST);
      gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
      gen_instr(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 2);
      emit(PH_RST); emit(PH_RST);
      force_stray = 1'b1;
      s = q.size(); gen_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0); pin_addr(s, RST_PC);

      repeat (250) begin
         k    = int'($urandom_range(0, 19));
         kind = (k == 0) ? 3 : (k < 5) ? 1 : (k < 8) ? 2 : 0;
         err  = ((kind == 1 || kind == 2) && $urandom_range(0, 9) == 0) ? 1 : 0;
         cut  = ((kind == 1 || kind == 2) && $urandom_range(0, 29) == 0) ? 1 : -1;
         gen_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), kind,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   (cut < 0 && $urandom_range(0, 2) == 0) ? 1 : 0, err,
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom, cut);
         if (m_halted) repeat ($urandom_range(1, 3)) emit(PH_HALT);
         if (m_halted || cut >= 0) repeat ($urandom_range(1, 2)) emit(PH_RST);
      end

      for (int i = 0; i < q.size(); i++) begin
         @(posedge clk);
         #1;
         rst                = q[i].rst;
         bus.ifu_req_ready  = q[i].ifu_req_ready;
         bus.ifu_resp_valid = q[i].ifu_resp_valid;
         bus.ifu_resp_inst  = q[i].ifu_resp_inst;
         bus.lsu_req_ready  = q[i].lsu_req_ready;
         bus.lsu_resp_valid = q[i].lsu_resp_valid;
         bus.lsu_resp_err   = q[i].lsu_resp_err;
         {dec_mem_rd, dec_mem_wr, dec_gpr_wen, dec_csr_wen, dec_jump, dec_ebreak} = q[i].dec;
         jump_pc            = q[i].jump_pc;
         cur                = q[i];
         cur_en             = 1'b1;
      end
      @(posedge clk);
      #1 cur_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
